ntt_stage_scheduler: RTL

Sequencer for the 128-point NTT datapath. It runs after all 128 coefficients are in the working buffer. It issues the butterfly commands (u/v addresses and twiddle index into the GMb table) for the 7 stages in golden-model order, and tracks in-flight butterflies so no stage starts before the previous stage's writebacks land. It then streams the 128 read addresses to the output side and signals completion.

---
 rtl/ntt_stage_scheduler.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ntt_stage_scheduler.sv
// ntt_stage_scheduler: issues 7x64 NTT butterflies in golden-model order
// under an in-flight window with per-stage barriers, then streams reads.
module ntt_stage_scheduler #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       bf_valid,
  input  logic       bf_ready,
  output logic [6:0] bf_addr_u,
  output logic [6:0] bf_addr_v,
  output logic [6:0] bf_tw_idx,
  input  logic       bf_wb,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [6:0] rd_addr,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, BARRIER, OUTPUT
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUT);

  state_t           state_q, state_d;
  logic [2:0]       stage_q, stage_d;
  logic [5:0]       k_q, k_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [6:0]       rd_q, rd_d;
  logic             bfv_q, bfv_d;
  logic             rdv_q, rdv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [6:0]       u_q, u_d;
  logic [6:0]       v_q, v_d;
  logic [6:0]       tw_q, tw_d;
  logic [6:0]       ht, ii, off, jj, tw;
  logic             bf_hs, rd_hs;

  assign bf_hs = bfv_q & bf_ready;
  assign rd_hs = rdv_q & rd_ready;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    out_d   = out_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    // a writeback with nothing in flight is spurious
    unique case ({bf_hs, bf_wb})
      2'b10: out_d = out_q + CNT_W'(1);
      2'b01: begin
        if (out_q == '0) err_d = 1'b1;
        else out_d = out_q - CNT_W'(1);
      end
      default: ;
    endcase

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          busy_d  = 1'b1;
          stage_d = '0;
          k_d     = '0;
          err_d   = 1'b0;
        end
      end
      ISSUE: begin
        if (bf_hs) begin
          k_d = k_q + 6'd1;
          if (k_q == 6'd63) state_d = BARRIER;
        end
      end
      BARRIER: begin
        if (out_d == '0) begin
          if (stage_q == 3'd6) begin
            state_d = OUTPUT;
            rd_d    = '0;
          end else begin
            state_d = ISSUE;
            stage_d = stage_q + 3'd1;
            k_d     = '0;
          end
        end
      end
      OUTPUT: begin
        if (rd_hs) begin
          rd_d = rd_q + 7'd1;
          if (rd_q == 7'd127) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    bfv_d = (state_d == ISSUE) && (out_d < MAX_C);
    rdv_d = (state_d == OUTPUT);
  end

  // butterfly fields for the next command, derived from (stage, k)
  always_comb begin
    ht   = 7'd64 >> stage_d;
    ii   = {1'b0, k_d} >> (3'd6 - stage_d);
    off  = {1'b0, k_d} & (ht - 7'd1);
    jj   = (ii << (3'd7 - stage_d)) + off;
    tw   = (7'd1 << stage_d) + ii;
    u_d  = bfv_d ? jj : '0;
    v_d  = bfv_d ? (jj + ht) : '0;
    tw_d = bfv_d ? tw : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      k_q     <= '0;
      out_q   <= '0;
      rd_q    <= '0;
      bfv_q   <= 1'b0;
      rdv_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      u_q     <= '0;
      v_q     <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      out_q   <= out_d;
      rd_q    <= rd_d;
      bfv_q   <= bfv_d;
      rdv_q   <= rdv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      u_q     <= u_d;
      v_q     <= v_d;
      tw_q    <= tw_d;
    end
  end

  assign bf_valid  = bfv_q;
  assign bf_addr_u = u_q;
  assign bf_addr_v = v_q;
  assign bf_tw_idx = tw_q;
  assign rd_valid  = rdv_q;
  assign rd_addr   = rd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
